if_fetch_unit: RTL and testbench

Instruction fetch stage feeding the IF/ID pipeline register. Holds the fetch PC, runs a req/ack handshake against instruction memory with at most one outstanding request, and buffers returned words in a small prefetch FIFO. Each cycle the IF/ID register is not frozen, the unit presents one `{pc, instruction}` pair or a bubble. Taken branches redirect fetch and discard everything in flight.

---
 rtl/arm_fetch_pkg.sv | 28 ++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/if_fetch_unit.sv | 127 ++++++++++++
 tb/tb_if_fetch_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_fetch_pkg.sv
`default_nettype none
// ==========================================================================
// Module   : arm_fetch_pkg -- shared types and constants for the fetch stage
// Revision : 1.0
// ==========================================================================
package arm_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // 32-bit wrapping increment; alignment is deliberately not checked.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ==========================================================================
// Module   : fetch_fifo -- DEPTH x 64 prefetch buffer with clear
// Revision : 1.0
// ==========================================================================
module fetch_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [63:0]                push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH):0]     count,
    output logic [63:0]                head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [63:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap for free.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only looked at while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ==========================================================================
// Module   : if_fetch_unit -- fetch PC, imem req/ack handshake, prefetch FIFO
// Revision : 1.0
// ==========================================================================
module if_fetch_unit
    import arm_fetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    fetch_state_t  state_q, state_d;
    logic          imem_req_q, imem_req_d;
    logic [31:0]   imem_addr_q, imem_addr_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;

    logic [CNT_W-1:0] fifo_count;
    logic [63:0]      fifo_head;
    fetch_entry_t     head_entry;
    fetch_entry_t     push_entry;

    logic             xfer;
    logic             has_head;
    logic             push;
    logic             pop;
    logic [31:0]      ret_pc;
    logic [OCC_W-1:0] occupancy;
    logic             room;

    fetch_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (branch_taken),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign head_entry = fifo_head;

    always_comb begin
        xfer       = imem_req_q && imem_ack;
        has_head   = (fifo_count != '0);
        pop        = has_head && !freeze && !branch_taken;
        push       = xfer && (state_q == REQ) && !branch_taken;
        ret_pc     = next_pc(imem_addr_q);
        push_entry = '{pc: ret_pc, instr: imem_rdata};
        // Occupancy after this cycle's push/pop: a new request may only be
        // issued if its data is guaranteed a slot when it returns.
        occupancy  = OCC_W'(fifo_count) + OCC_W'(push) - OCC_W'(pop);
        room       = (occupancy < OCC_W'(FIFO_DEPTH));

        state_d     = state_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        fetch_pc_d  = fetch_pc_q;

        if (branch_taken) begin
            fetch_pc_d = branch_addr;
            if ((state_q != IDLE) && !imem_ack) begin
                // Old request must finish on the bus; its data is thrown away.
                state_d = DROP;
            end else begin
                state_d     = REQ;
                imem_req_d  = 1'b1;
                imem_addr_d = branch_addr;
            end
        end else begin
            if (push) begin
                fetch_pc_d = ret_pc;
            end
            if ((state_q == IDLE) || xfer) begin
                if (room) begin
                    state_d     = REQ;
                    imem_req_d  = 1'b1;
                    imem_addr_d = fetch_pc_d;
                end else begin
                    state_d    = IDLE;
                    imem_req_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= 32'h0;
            fetch_pc_q  <= RESET_PC;
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            fetch_pc_q  <= fetch_pc_d;
        end
    end

    assign imem_req        = imem_req_q;
    assign imem_addr       = imem_addr_q;
    assign valid_out       = has_head && !branch_taken;
    assign pc_out          = valid_out ? head_entry.pc    : 32'h0;
    assign instruction_out = valid_out ? head_entry.instr : NOP_INSTR;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`timescale 1ns/1ps
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acks_left = 0;
    logic        ack_every3 = 1'b0;
    logic        last_xfer = 1'b0;
    logic [63:0] sb[$];
    logic [63:0] mon_exp;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .FIFO_DEPTH      (2),
        .RESET_PC        (32'h0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    assign imem_rdata = imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    // Scoreboard consumer: every consumed head must match the next expected pair.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (valid_out && !freeze && !branch_taken) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got pc=%h instr=%h, required no output", pc_out, instruction_out);
                end else begin
                    mon_exp = sb.pop_front();
                    if ({pc_out, instruction_out} !== mon_exp) begin
                        errors++;
                        $display("FAIL sb_pair: got pc=%h instr=%h, required pc=%h instr=%h",
                                 pc_out, instruction_out, mon_exp[63:32], mon_exp[31:0]);
                    end
                end
            end else if (!valid_out) begin
                checks++;
                if (pc_out !== 32'h0 || instruction_out !== 32'h0) begin
                    errors++;
                    $display("FAIL bubble: got pc=%h instr=%h, required 0/0", pc_out, instruction_out);
                end
            end
        end
    end

    task automatic tick();
        logic was_xfer;
        was_xfer = imem_req && imem_ack;
        @(posedge clk);
        #1;
        cyc++;
        last_xfer = was_xfer;
        if (was_xfer && acks_left > 0) acks_left--;
        imem_ack = (acks_left > 0) && (!ack_every3 || (cyc % 3 == 0));
    endtask

    task automatic set_acks(input int n);
        acks_left = n;
        imem_ack  = (n > 0) && (!ack_every3 || (cyc % 3 == 0));
    endtask

    task automatic push_stream(input logic [31:0] base, input int n);
        logic [31:0] a;
        a = base;
        for (int k = 0; k < n; k++) begin
            sb.push_back({a + 32'd4, mem_word(a)});
            a = a + 32'd4;
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d entries pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_req(input string name, input logic [31:0] addr);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== addr) begin
            errors++;
            $display("FAIL %s: got req=%b addr=%h, required req=1 addr=%h", name, imem_req, imem_addr, addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0; imem_ack = 1'b0;
        tick();
        tick();
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_req: got req=%b addr=%h, required 0/0", imem_req, imem_addr);
        end
        checks++;
        if (valid_out !== 1'b0 || pc_out !== 32'h0 || instruction_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: got v=%b pc=%h instr=%h, required 0/0/0", valid_out, pc_out, instruction_out);
        end
        push_stream(32'h0, 8);
        set_acks(8);
        rst_n = 1'b1;
        tick();
        check_req("first_req", 32'h0);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL first_valid: got %b, required 0", valid_out);
        end
        tick();
        check_req("seq_addr4", 32'h4);
        checks++;
        if (valid_out !== 1'b1 || pc_out !== 32'h4 || instruction_out !== mem_word(32'h0)) begin
            errors++;
            $display("FAIL first_data: got v=%b pc=%h instr=%h, required 1/%h/%h",
                     valid_out, pc_out, instruction_out, 32'h4, mem_word(32'h0));
        end
        tick();
        check_req("seq_addr8", 32'h8);
        tick();
        check_req("seq_addr12", 32'hC);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (valid_out !== 1'b1) begin
                errors++;
                $display("FAIL no_bubble: got valid=%b at step %0d, required 1", valid_out, i);
            end
        end
        tick();
        check_req("hold_after_budget", 32'h20);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL empty_after_budget: got valid=%b, required 0", valid_out);
        end
        wait_drain(5, "startup");
    endtask

    task automatic test_wait_states();
        logic [31:0] exp_addr;
        int          bubbles;
        exp_addr = 32'h20;
        bubbles  = 0;
        push_stream(32'h20, 6);
        ack_every3 = 1'b1;
        set_acks(6);
        for (int i = 0; i < 60; i++) begin
            if (imem_req) begin
                checks++;
                if (imem_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL wait_addr: got %h, required %h", imem_addr, exp_addr);
                end
            end
            if (!valid_out) bubbles++;
            tick();
            if (last_xfer) exp_addr = exp_addr + 32'd4;
            if (acks_left == 0 && sb.size() == 0) break;
        end
        checks++;
        if (bubbles == 0) begin
            errors++;
            $display("FAIL wait_bubbles: got %0d bubbles, required >0", bubbles);
        end
        wait_drain(5, "wait_states");
        ack_every3 = 1'b0;
    endtask

    task automatic test_freeze_full();
        push_stream(32'h38, 3);
        freeze = 1'b1;
        set_acks(3);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req !== 1'b0) begin
                errors++;
                $display("FAIL freeze_noreq: got req=%b, required 0", imem_req);
            end
            checks++;
            if (valid_out !== 1'b1 || pc_out !== 32'h3C || instruction_out !== mem_word(32'h38)) begin
                errors++;
                $display("FAIL freeze_head: got v=%b pc=%h instr=%h, required 1/%h/%h",
                         valid_out, pc_out, instruction_out, 32'h3C, mem_word(32'h38));
            end
            tick();
        end
        freeze = 1'b0;
        wait_drain(10, "freeze");
    endtask

    task automatic test_branch_outstanding();
        push_stream(32'h100, 4);
        branch_taken = 1'b1;
        branch_addr  = 32'h100;
        tick();
        branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            check_req("drop_hold", 32'h44);
        end
        set_acks(5);
        tick();
        check_req("branch_target_req", 32'h100);
        tick();
        checks++;
        if (valid_out !== 1'b1 || pc_out !== 32'h104 || instruction_out !== mem_word(32'h100)) begin
            errors++;
            $display("FAIL branch_target_out: got v=%b pc=%h instr=%h, required 1/%h/%h",
                     valid_out, pc_out, instruction_out, 32'h104, mem_word(32'h100));
        end
        wait_drain(10, "branch_out");
    endtask

    task automatic test_branch_ack_freeze();
        push_stream(32'h200, 2);
        freeze = 1'b1;
        set_acks(1);
        tick();
        checks++;
        if (valid_out !== 1'b1 || pc_out !== 32'h114) begin
            errors++;
            $display("FAIL prebranch_head: got v=%b pc=%h, required 1/%h", valid_out, pc_out, 32'h114);
        end
        branch_taken = 1'b1;
        branch_addr  = 32'h200;
        set_acks(3);
        #1;
        checks++;
        if (valid_out !== 1'b0 || pc_out !== 32'h0 || instruction_out !== 32'h0) begin
            errors++;
            $display("FAIL branch_bubble: got v=%b pc=%h instr=%h, required 0/0/0", valid_out, pc_out, instruction_out);
        end
        tick();
        branch_taken = 1'b0;
        freeze = 1'b0;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL branch_clear: got valid=%b, required 0", valid_out);
        end
        check_req("ack_branch_req", 32'h200);
        wait_drain(10, "branch_ack");
    endtask

    task automatic test_wrap_async_reset();
        push_stream(32'hFFFF_FFFC, 2);
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        set_acks(3);
        tick();
        branch_taken = 1'b0;
        check_req("wrap_req", 32'hFFFF_FFFC);
        tick();
        check_req("wrap_next", 32'h0);
        checks++;
        if (valid_out !== 1'b1 || pc_out !== 32'h0 || instruction_out !== mem_word(32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL wrap_pc: got v=%b pc=%h instr=%h, required 1/%h/%h",
                     valid_out, pc_out, instruction_out, 32'h0, mem_word(32'hFFFF_FFFC));
        end
        wait_drain(10, "wrap");
        freeze = 1'b1;
        set_acks(1);
        tick();
        check_req("pre_reset_req", 32'h8);
        checks++;
        if (valid_out !== 1'b1 || pc_out !== 32'h8) begin
            errors++;
            $display("FAIL pre_reset_head: got v=%b pc=%h, required 1/%h", valid_out, pc_out, 32'h8);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_req: got req=%b addr=%h, required 0/0", imem_req, imem_addr);
        end
        checks++;
        if (valid_out !== 1'b0 || pc_out !== 32'h0 || instruction_out !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_out: got v=%b pc=%h instr=%h, required 0/0/0", valid_out, pc_out, instruction_out);
        end
        tick();
        rst_n = 1'b1;
        freeze = 1'b0;
        set_acks(0);
        tick();
        check_req("restart_req", 32'h0);
    endtask

    initial begin
        test_reset();
        test_wait_states();
        test_freeze_full();
        test_branch_outstanding();
        test_branch_ack_freeze();
        test_wrap_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
